// File: rtl/serial_rx_8_if.sv
// serial_rx_8_if: control, data and status bundle between serial_rx_8 and its upstream/consumer
interface serial_rx_8_if #(parameter int WIDTH = 8);
    logic                     Start;
    logic                     Serial_In;
    logic                     Bit_En;
    logic                     Data_Ack;
    logic [WIDTH-1:0]         Data_Out;
    logic                     Data_Valid;
    logic                     Busy;
    logic                     Overrun;
    logic [$clog2(WIDTH)-1:0] Bit_Count;
    modport master (
        output Start, Serial_In, Bit_En, Data_Ack,
        input  Data_Out, Data_Valid, Busy, Overrun, Bit_Count
    );
    modport slave (
        input  Start, Serial_In, Bit_En, Data_Ack,
        output Data_Out, Data_Valid, Busy, Overrun, Bit_Count
    );
endinterface

// File: rtl/serial_rx_8.sv
// serial_rx_8: strobed serial-to-parallel receiver with a one-word holding register and sticky overrun
module serial_rx_8 #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input logic          Clk,
    input logic          Reset,
    serial_rx_8_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic {IDLE, RECV} state_t;
    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt, data_q;
    logic [CW-1:0]    cnt;
    logic             valid_q, ovr_q, take, done;

    always_ff @(posedge Clk)
        state <= Reset ? IDLE : state_nxt;

    // Start outranks a coincident strobe in either state, so that bit is never taken
    always_comb begin
        take      = state == RECV && bus.Bit_En && !bus.Start;
        done      = take && cnt == LAST;
        shreg_nxt = LSB_FIRST ? {bus.Serial_In, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], bus.Serial_In};
        state_nxt = bus.Start ? RECV : done ? IDLE : state;
    end

    always_comb begin
        bus.Busy       = state == RECV;
        bus.Data_Out   = data_q;
        bus.Data_Valid = valid_q;
        bus.Overrun    = ovr_q;
        bus.Bit_Count  = cnt;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            shreg   <= '0;
            cnt     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (bus.Start) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (take) begin
                shreg <= shreg_nxt;
                cnt   <= done ? '0 : cnt + 1'b1;
            end
            // a same-cycle ack frees the holding register for the word completing now
            if (done && (!valid_q || bus.Data_Ack)) begin
                data_q  <= shreg_nxt;
                valid_q <= 1'b1;
            end else if (done)
                ovr_q <= 1'b1;
            else if (bus.Data_Ack)
                valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_rx_8.sv
// tb_serial_rx_8: scoreboard bench for LSB-first and MSB-first serial_rx_8 instances
module tb_serial_rx_8;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    serial_rx_8_if #(.WIDTH(8)) lb ();
    serial_rx_8_if #(.WIDTH(8)) mb ();
    serial_rx_8 #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (.Clk(Clk), .Reset(Reset), .bus(lb.slave));
    serial_rx_8 #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (.Clk(Clk), .Reset(Reset), .bus(mb.slave));

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] md = 8'h00;
    logic       mv = 1'b0, movr = 1'b0;
    logic [7:0] d;
    logic       v, b, o;
    logic [2:0] c;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input bit m, input logic st, input logic en, input logic si, input logic ack);
        if (m) begin
            mb.Start = st; mb.Bit_En = en; mb.Serial_In = si; mb.Data_Ack = ack;
        end else begin
            lb.Start = st; lb.Bit_En = en; lb.Serial_In = si; lb.Data_Ack = ack;
        end
    endtask

    task automatic get(input bit m);
        if (m) begin
            d = mb.Data_Out; v = mb.Data_Valid; b = mb.Busy; o = mb.Overrun; c = mb.Bit_Count;
        end else begin
            d = lb.Data_Out; v = lb.Data_Valid; b = lb.Busy; o = lb.Overrun; c = lb.Bit_Count;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        md = 8'h00; mv = 1'b0; movr = 1'b0;
    endtask

    task automatic send_bits(input bit m, input logic [7:0] w, input bit ack_last);
        for (int i = 0; i < 8; i++) begin
            drive(m, 1'b0, 1'b1, m ? w[7-i] : w[i], ack_last && i == 7);
            tick();
        end
        drive(m, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic recv(input bit m, input logic [7:0] w, input bit ack_last);
        if (!mv || ack_last) begin
            exp_q.push_back(w);
            mv = 1'b1;
        end else
            movr = 1'b1;
        drive(m, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        send_bits(m, w, ack_last);
    endtask

    task automatic ack(input bit m);
        drive(m, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(m, 1'b0, 1'b0, 1'b0, 1'b0);
        mv = 1'b0;
    endtask

    task automatic pop();
        if (exp_q.size() > 0) md = exp_q.pop_front();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        model_reset();
        get(0);
        checks++; if ({d, v, b, o, c} !== 14'h0) begin errors++; $display("FAIL reset_lsb got %h want 0", {d, v, b, o, c}); end
        get(1);
        checks++; if ({d, v, b, o, c} !== 14'h0) begin errors++; $display("FAIL reset_msb got %h want 0", {d, v, b, o, c}); end
    endtask

    task automatic test_nominal();
        int bn;
        logic [7:0] w = 8'hA5;
        exp_q.push_back(w);
        mv = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        bn = int'(lb.Busy);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b0, 1'b1, w[i], 1'b0);
            tick();
            bn += int'(lb.Busy);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        get(0);
        pop();
        checks++; if (d !== md) begin errors++; $display("FAIL nominal_data got %h want %h", d, md); end
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL nominal_valid got %b want 1", v); end
        checks++; if (bn !== 8) begin errors++; $display("FAIL nominal_busy_cycles got %0d want 8", bn); end
        checks++; if ({b, c} !== 4'h0) begin errors++; $display("FAIL nominal_idle got %h want 0", {b, c}); end
        ack(0);
        get(0);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL ack_valid got %b want 0", v); end
        checks++; if (d !== md) begin errors++; $display("FAIL ack_data_held got %h want %h", d, md); end
    endtask

    task automatic test_gapped();
        logic [7:0] w = 8'hA5;
        logic [2:0] e;
        exp_q.push_back(w);
        mv = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            e = 3'(i + 1);
            drive(0, 1'b0, 1'b1, w[i], 1'b0);
            tick();
            get(0);
            checks++; if (c !== e) begin errors++; $display("FAIL gap_count bit %0d got %0d want %0d", i, c, e); end
            drive(0, 1'b0, 1'b0, ~w[i], 1'b0);
            tick();
            get(0);
            checks++; if (c !== e) begin errors++; $display("FAIL gap_hold bit %0d got %0d want %0d", i, c, e); end
        end
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        get(0);
        pop();
        checks++; if ({v, d} !== {1'b1, md}) begin errors++; $display("FAIL gap_data got %h want %h", {v, d}, {1'b1, md}); end
        ack(0);
    endtask

    task automatic test_overrun();
        recv(0, 8'h3C, 1'b0);
        get(0);
        pop();
        checks++; if ({v, d} !== {1'b1, md}) begin errors++; $display("FAIL ovr_first got %h want %h", {v, d}, {1'b1, md}); end
        recv(0, 8'hFF, 1'b0);
        get(0);
        pop();
        checks++; if (d !== md) begin errors++; $display("FAIL ovr_data_kept got %h want %h", d, md); end
        checks++; if ({v, o} !== {mv, movr}) begin errors++; $display("FAIL ovr_flags got %b want %b", {v, o}, {mv, movr}); end
        recv(0, 8'h81, 1'b1);
        get(0);
        pop();
        checks++; if (d !== md) begin errors++; $display("FAIL ack_complete_data got %h want %h", d, md); end
        checks++; if ({v, o} !== 2'b11) begin errors++; $display("FAIL ack_complete_flags got %b want 11", {v, o}); end
    endtask

    task automatic test_restart();
        test_reset();
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        get(0);
        checks++; if (c !== 3'd4) begin errors++; $display("FAIL partial_count got %0d want 4", c); end
        drive(0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        get(0);
        checks++; if ({b, c} !== 4'b1000) begin errors++; $display("FAIL restart_state got %b want 1000", {b, c}); end
        exp_q.push_back(8'h12);
        mv = 1'b1;
        send_bits(0, 8'h12, 1'b0);
        get(0);
        pop();
        checks++; if ({v, d} !== {1'b1, md}) begin errors++; $display("FAIL restart_data got %h want %h", {v, d}, {1'b1, md}); end
        ack(0);
        drive(0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        get(0);
        checks++; if ({b, c} !== 4'b1000) begin errors++; $display("FAIL idle_start_bit got %b want 1000", {b, c}); end
        exp_q.push_back(8'h5A);
        mv = 1'b1;
        send_bits(0, 8'h5A, 1'b0);
        get(0);
        pop();
        checks++; if ({v, d} !== {1'b1, md}) begin errors++; $display("FAIL idle_start_data got %h want %h", {v, d}, {1'b1, md}); end
    endtask

    task automatic test_reset_mid();
        recv(0, 8'hFF, 1'b0);
        get(0);
        checks++; if ({v, o} !== {mv, movr}) begin errors++; $display("FAIL pre_reset_flags got %b want %b", {v, o}, {mv, movr}); end
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        model_reset();
        get(0);
        checks++; if ({d, v, b, o, c} !== 14'h0) begin errors++; $display("FAIL mid_reset got %h want 0", {d, v, b, o, c}); end
        for (int i = 0; i < 3; i++) tick();
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        get(0);
        checks++; if ({v, b, c} !== 5'h0) begin errors++; $display("FAIL idle_strobe got %h want 0", {v, b, c}); end
    endtask

    task automatic test_msb_first();
        model_reset();
        recv(1, 8'hA5, 1'b0);
        get(1);
        pop();
        checks++; if ({v, d} !== {1'b1, md}) begin errors++; $display("FAIL msb_a5 got %h want %h", {v, d}, {1'b1, md}); end
        ack(1);
        recv(1, 8'h12, 1'b0);
        get(1);
        pop();
        checks++; if ({v, d} !== {1'b1, md}) begin errors++; $display("FAIL msb_12 got %h want %h", {v, d}, {1'b1, md}); end
    endtask

    task automatic test_back_to_back();
        model_reset();
        recv(0, 8'h69, 1'b0);
        get(0);
        pop();
        checks++; if ({v, d} !== {1'b1, md}) begin errors++; $display("FAIL b2b_first got %h want %h", {v, d}, {1'b1, md}); end
        recv(0, 8'h96, 1'b1);
        get(0);
        pop();
        checks++; if ({v, o, d} !== {2'b10, md}) begin errors++; $display("FAIL b2b_second got %h want %h", {v, o, d}, {2'b10, md}); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_nominal();
        test_gapped();
        test_overrun();
        test_restart();
        test_reset_mid();
        test_msb_first();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_rx_8.md
# serial_rx_8

Serial-to-parallel receiver that sits at the far end of the 8-bit shift-register data path. It samples the serial stream emitted LSB-first by a shifting register, one bit per `Bit_En` strobe, after the upstream `Shift_En`. It assembles `WIDTH` bits into a word and presents the word in a one-entry holding register with a valid/ack handshake. It also reports overrun when a finished word arrives before the previous one is consumed.

## Interface

**Parameters**
- `WIDTH`, default 8: word length in bits. Legal range 2..16.
- `LSB_FIRST`, default 1: bit order of the incoming stream.
  - 1: first received bit lands in bit 0.
  - 0: first received bit lands in bit `WIDTH-1`.

**Ports**
- `Clk`, input, 1: clock; all state changes on the rising edge.
- `Reset`, input, 1: synchronous reset, active-high.
- `Start`, input, 1: begin (or restart) reception of a word.
- `Serial_In`, input, 1: serial data bit. Connects to the upstream `Shift_Out`.
- `Bit_En`, input, 1: sample strobe. One bit is accepted per cycle in which it is high.
- `Data_Ack`, input, 1: consumer has taken `Data_Out`.
- `Data_Out`, output, `WIDTH`: holding register, i.e. the last completed word.
- `Data_Valid`, output, 1: `Data_Out` holds an unconsumed word.
- `Busy`, output, 1: reception in progress (FSM is in RECV).
- `Overrun`, output, 1: sticky flag. A completed word was dropped.
- `Bit_Count`, output, `$clog2(WIDTH)`: bits received in the current word.

## Operation

**FSM states**
- IDLE: `Bit_En` is ignored.
- RECV: bits are accepted.

**IDLE**
- `Start`=1 → shift register cleared, `Bit_Count`←0, next state RECV.
- `Start` together with `Bit_En` in IDLE: `Start` wins; that bit is not sampled.

**RECV, on `Bit_En`=1**
- Shift register update:
  - `LSB_FIRST`=1: shreg ← {`Serial_In`, shreg[`WIDTH-1`:1]}.
  - `LSB_FIRST`=0: shreg ← {shreg[`WIDTH-2`:0], `Serial_In`}.
- `Bit_Count` increments by 1.

**Completion** (`Bit_En`=1 with `Bit_Count`=`WIDTH-1`)
- The word including the current bit is the completed word.
- `Bit_Count`←0 and the FSM returns to IDLE.
- If the holding register is free, or `Data_Ack`=1 in the same cycle: `Data_Out` ← completed word, `Data_Valid`←1.
- Otherwise (`Data_Valid`=1, `Data_Ack`=0): the completed word is discarded, `Data_Out` is unchanged, `Overrun`←1.

**Other rules**
- `Start`=1 in RECV: restart. Shift register and `Bit_Count` are cleared and the state stays RECV. The partial word is abandoned, and a coincident `Bit_En` bit is discarded. The holding register is unaffected.
- `Data_Ack`=1 with `Data_Valid`=1 and no completion → `Data_Valid`←0. `Data_Out` retains its value.
- `Data_Ack` with `Data_Valid`=0 has no effect.
- `Overrun` is cleared only by `Reset`.
- `Busy` is decoded directly from the state register (RECV=1).

**Reset** (synchronous, any state, including mid-word and with a pending word)
- State IDLE.
- Shift register, `Data_Out`, `Bit_Count` = 0.
- `Data_Valid`, `Overrun`, `Busy` = 0.

## Timing

- All outputs are registered or state-decoded; there is no combinational path from inputs to outputs.
- `Busy` goes high the cycle after the `Start` edge. It goes low the cycle after the completing `Bit_En` edge.
- `Data_Valid` and the new `Data_Out` are visible the cycle after the completing `Bit_En`.
  - Minimum latency is `WIDTH`+1 edges from `Start` with back-to-back `Bit_En`. For `WIDTH`=8 that is 9 edges.
- Gaps in `Bit_En` stall reception indefinitely; there is no timeout.
- `Data_Valid` falls the cycle after `Data_Ack`.
- Back-to-back words: `Start` may be asserted in the cycle immediately after completion (first IDLE cycle).

## Test plan

1. **Nominal receive.** Reset, then `Start`, then 8 consecutive `Bit_En` with `Serial_In` = 1,0,1,0,0,1,0,1. → `Data_Out`=0xA5 and `Data_Valid`=1 on the cycle after the 8th bit. `Busy` is 1 for exactly 8 cycles.
2. **Gapped strobes.** Same bits with `Bit_En` high only on alternate cycles → `Data_Out`=0xA5. `Bit_Count` steps 0..7 then returns to 0. Ignored cycles do not shift.
3. **Overrun, then ack-coincident completion.**
   - Receive 0x3C and leave it un-acked, then receive 0xFF → `Data_Out` stays 0x3C, `Overrun`=1.
   - Receive 0x81 with `Data_Ack`=1 on the completing cycle → `Data_Out`=0x81, `Data_Valid` stays 1.
4. **Restart mid-word.**
   - Send 4 bits of 1s, then `Start`+`Bit_En` together, then 8 bits encoding 0x12 → `Data_Out`=0x12. The partial bits and the coincident bit are lost.
   - `Start`+`Bit_En` in IDLE → that bit is not counted.
5. **Reset mid-operation.** `Reset` after 5 bits, with `Data_Valid`=1 and `Overrun`=1 → next cycle all outputs are 0 and the state is IDLE. `Bit_En` without `Start` then leaves `Bit_Count`=0.
6. **MSB-first variant.** `LSB_FIRST`=0, bits 1,0,1,0,0,1,0,1 → `Data_Out`=0xA5. Bits 0,0,0,1,0,0,1,0 → 0x12.
